// File: rtl/acc_pkg.sv
// acc_pkg: shared defaults and the saturating adder for the partial-sum accumulator.
package acc_pkg;
    localparam int TILE_LEN = 16;
    localparam int LANES_DEF = 8;
    localparam int IW_DEF = 20;
    localparam int AW_DEF = 32;

    typedef struct packed {
        logic              sat;
        logic signed [63:0] val;
    } sat_t;

    // Operands arrive sign-extended to 64 bits; the result is clamped to the signed aw-bit range.
    function automatic sat_t sat_add(input logic signed [63:0] a, input logic signed [63:0] b, input int aw);
        logic signed [63:0] s;
        logic signed [63:0] mx;
        logic signed [63:0] mn;
        sat_t r;
        s = a + b;
        mx = (64'sd1 <<< (aw - 1)) - 64'sd1;
        mn = -mx - 64'sd1;
        r.sat = (s > mx) || (s < mn);
        r.val = (s > mx) ? mx : (s < mn) ? mn : s;
        return r;
    endfunction
endpackage

// File: rtl/psum_bank.sv
// psum_bank: tile-deep register file, one combinational read port and one synchronous write port.
module psum_bank #(
    parameter int W = 256,
    parameter int DEPTH = 16,
    localparam int XW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [XW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [XW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/psum_accum.sv
// psum_accum: accumulates PE partial sums across channel passes and emits final sums over valid/ready.
module psum_accum
    import acc_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int IW = IW_DEF,
    parameter int AW = AW_DEF,
    parameter int TILE = TILE_LEN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                p_valid,
    input  logic                last_ch,
    input  logic [LANES*IW-1:0] psum_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LANES*AW-1:0] out_data,
    output logic [3:0]          out_idx,
    output logic                out_last,
    output logic                stall_req,
    output logic                err_overrun,
    output logic                sat_flag
);
    localparam int XW = $clog2(TILE);

    logic [XW-1:0]       idx_q, idx_d, oidx_q, oidx_d;
    logic                first_q, first_d, ov_q, ov_d, err_q, err_d, sat_q, sat_d;
    logic [LANES*AW-1:0] od_q, od_d, rd, sum;
    logic [LANES-1:0]    lane_sat;
    logic                acc, fin, ovr, load, wrap;

    psum_bank #(.W(LANES*AW), .DEPTH(TILE)) u_bank (
        .clk  (clk),
        .we   (acc & ~last_ch),
        .waddr(idx_q),
        .wdata(sum),
        .raddr(idx_q),
        .rdata(rd)
    );

    // The first pass of a tile ignores whatever the bank holds.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        sat_t r;
        logic [63-AW:0] unused_hi;
        assign r = sat_add(first_q ? 64'sd0 : 64'(signed'(rd[k*AW +: AW])),
                           64'(signed'(psum_in[k*IW +: IW])), AW);
        assign sum[k*AW +: AW] = r.val[AW-1:0];
        assign lane_sat[k] = r.sat;
        assign unused_hi = r.val[63:AW];
    end

    always_comb begin
        acc = p_valid & ~stall;
        fin = acc & last_ch;
        ovr = fin & ov_q & ~out_ready;
        load = fin & ~ovr;
        wrap = idx_q == XW'(TILE - 1);
        idx_d = acc ? (wrap ? '0 : idx_q + 1'b1) : idx_q;
        first_d = (acc & wrap) ? last_ch : first_q;
        ov_d = load | (ov_q & ~out_ready);
        od_d = load ? sum : od_q;
        oidx_d = load ? idx_q : oidx_q;
        err_d = err_q | ovr;
        sat_d = sat_q | (acc & (|lane_sat));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
            first_q <= 1'b1;
            ov_q <= 1'b0;
            od_q <= '0;
            oidx_q <= '0;
            err_q <= 1'b0;
            sat_q <= 1'b0;
        end else begin
            idx_q <= idx_d;
            first_q <= first_d;
            ov_q <= ov_d;
            od_q <= od_d;
            oidx_q <= oidx_d;
            err_q <= err_d;
            sat_q <= sat_d;
        end
    end

    assign out_valid = ov_q;
    assign out_data = od_q;
    assign out_idx = 4'(oidx_q);
    assign out_last = ov_q & (oidx_q == XW'(TILE - 1));
    assign stall_req = ov_q & ~out_ready;
    assign err_overrun = err_q;
    assign sat_flag = sat_q;
endmodule

// File: doc/psum_accum.md
# psum_accum

Partial-sum accumulator sitting directly downstream of the PE array and its control FSM. It consumes the delay-aligned `p_valid_output` / `last_chanel_output` strobes and per-lane PE results. Across input-channel passes it accumulates 16-position tiles, and on the last-channel pass it emits final output-channel sums to the writeback stage over a valid/ready port. It also drives a stall request back to the FSM when writeback backpressures.

## Interface
- `LANES`, 8: parallel output lanes, one PE column each.
- `IW`, 20: signed width of each incoming PE partial sum.
- `AW`, 32: signed accumulator and output width; `AW` > `IW`.
- `TILE`, 16: positions per channel pass; must equal the FSM tile length.

- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  global stall, the same signal the FSM sees. While high, all state is frozen.
- `p_valid`  in  1  PE result valid; driven from FSM `p_valid_output`.
- `last_ch`  in  1  current pass is the last input channel; driven from FSM `last_chanel_output`. Constant for all `TILE` beats of a pass.
- `psum_in`  in  `LANES*IW`  packed signed partial sums; lane k is at `[k*IW +: IW]`.
- `out_valid`  out  1  final sum beat available.
- `out_ready`  in  1  writeback accepts the beat.
- `out_data`  out  `LANES*AW`  packed signed final sums.
- `out_idx`  out  4  tile position (0..`TILE`-1) of `out_data`.
- `out_last`  out  1  high on the beat with `out_idx == TILE-1`.
- `stall_req`  out  1  combinational `out_valid & ~out_ready`; ORed into the global stall outside this block.
- `err_overrun`  out  1  sticky error: a result was dropped.
- `sat_flag`  out  1  sticky: at least one lane saturated since reset.

## Operation
- Accumulator bank: `TILE` entries × `LANES` × `AW` bits, register-based. `idx` counts 0..`TILE`-1. The `first` flag marks the first channel pass.
- A beat is accepted when `p_valid & ~stall`. For each lane, `sum = first ? sext(psum_in) : bank[idx] + sext(psum_in)`.
  - Additions saturate to the signed `AW` range, and any saturation sets `sat_flag`.
- If `last_ch` is low, `bank[idx] <= sum`.
- If `last_ch` is high, `sum` goes to the output register (`out_data`, `out_idx = idx`, `out_valid = 1`) and the bank entry is left unwritten.
- `idx` increments on each accepted beat and wraps from `TILE-1` to 0.
  - On the wrap, `first <= last_ch`, so the pass after a last-channel pass starts a new accumulation.
- Output register: `out_valid` clears on `out_valid & out_ready` unless a new final beat loads in the same cycle. Load and drain in the same cycle is allowed, giving full throughput.
- Overrun: if a last-channel beat is accepted while `out_valid & ~out_ready`, the held output is preserved, the new sum is dropped, and `err_overrun` is set. `idx` and `first` still advance.
- Stall: while `stall` is high, `idx`, `first`, the bank and the output register all hold. `out_ready` handshakes still complete during stall, so writeback can drain and release the stall.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_idx=0`, `out_last=0`, `err_overrun=0`, `sat_flag=0`, `idx=0`, `first=1`. Bank contents are don't-care, because `first` forces an overwrite.
- Reset mid-pass abandons the partial tile; the next accepted beat is treated as idx 0 of a first pass.
- Latency: a final beat accepted at edge N has `out_valid` high after edge N. One register stage, no combinational path from `psum_in` to `out_data`.
- `stall_req` is combinational from `out_valid` and `out_ready` only. It has no path from `stall`, so no loop.
- Single-channel layer (`first` and `last_ch` both high): `sum = psum_in` is emitted directly.
- `p_valid` gaps inside a pass are legal; `idx` advances only on accepted beats.

## Structure
- Shared package `acc_pkg`: `TILE_LEN = 16`, `LANES`, `IW`, `AW` defaults, and the saturating-add function `sat_add`.
- One sub-module, `psum_bank`: the `TILE`-entry register file with one combinational read port and one synchronous write port. The top level holds the control, the adders and the output register.

## Test plan
- Reset, then 1 pass with `last_ch=1` and `psum_in` lane k = idx+k, `out_ready=1` → 16 output beats, `out_data` lane k = idx+k, `out_last` on idx 15.
- 3 passes of constant lane value 5, `last_ch` high only on pass 3 → outputs all 15; a following 2-pass tile of value 1 → outputs all 2 (`first` restart verified).
- Hold `out_ready=0` on the last pass with the FSM model honoring `stall_req` → `stall_req` high, no data lost, 16 beats in order after `out_ready` returns, `err_overrun=0`.
- Ignore `stall_req` with `out_ready=0` → first held beat (idx 0) preserved, `err_overrun=1`, `idx` wraps normally.
- Accumulate `IW` max positive (524287) over 5000 passes with `AW=20` override → outputs clamp at 524287, `sat_flag=1`.
- Assert `rst` at idx 7 of pass 2 → outputs cleared; the next 1-pass tile of value 3 → outputs 3, no residue from the old bank.
